// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: MIPS funct codes,
// the controller state encoding and small funct decode helpers.
// The optional early-exit multiply is enabled with the MD_EARLY_OUT_EN macro
// (consumed in md_sequencer.sv).
package md_pkg;

    // Default operand width and the matching iteration-counter width.
    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    // MIPS SPECIAL funct codes handled by the sequencer.
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // True for the four funct codes the sequencer accepts.
    function automatic logic is_md_funct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) ||
               (fn == FN_DIV)  || (fn == FN_DIVU);
    endfunction

    // True for the signed variants (MULT, DIV).
    function automatic logic is_signed_funct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_DIV);
    endfunction

    // True for the divide variants (DIV, DIVU).
    function automatic logic is_div_funct(input logic [5:0] fn);
        return (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
//   multiply: acc += opnd when low[0] is set, then {acc, low} >>= 1
//             (low holds the multiplier, the product's low half shifts in)
//   divide:   {acc, low} <<= 1, trial-subtract opnd (divisor) from acc,
//             keep the difference and set quotient bit 0 when it is non-negative
//             (low holds the dividend, the quotient shifts in from the right)
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] low_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] low_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    // Compute both step flavours and select by operation type.
    always_comb begin
        acc_o  = acc_i;
        low_o  = low_i;
        sum    = acc_i + (low_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i[WIDTH-1:0], low_i[WIDTH-1]};
        // One extra bit so the borrow of the trial subtraction is visible.
        diff   = {1'b0, rem_sh} - {2'b00, opnd_i};
        if (is_div_i) begin
            if (!diff[WIDTH+1]) begin
                acc_o = diff[WIDTH:0];
                low_o = {low_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = rem_sh;
                low_o = {low_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {1'b0, sum[WIDTH:1]};
            low_o = {sum[0], low_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller for the MIPS execute stage.
// Owns HI/LO (including MTHI/MTLO writes) and holds busy while an operation
// is in flight so the hazard unit can stall MFHI/MFLO and new issues.
// Signed operations run on magnitudes; the sign fixup happens in FIX.
// Define MD_EARLY_OUT_EN to let multiplies leave RUN as soon as the remaining
// multiplier bits are zero (the product is realigned in FIX).
//
// Handshake: start is only sampled in IDLE and only with a legal funct;
// flush beats start in the same cycle and squashes RUN/FIX without touching
// HI/LO; done is a one-cycle pulse in the cycle after HI/LO take a result.
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e        state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH:0]   acc_q,     acc_d;
    logic [WIDTH-1:0] low_q,     low_d;
    logic [WIDTH-1:0] opnd_q,    opnd_d;
    logic             is_div_q,  is_div_d;
    logic             neg_q,     neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic             done_q,    done_d;

    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_low;
    logic               early_exit;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fx;
    logic [WIDTH-1:0]   quo_fx;
    logic [WIDTH-1:0]   rem_fx;
`ifdef MD_EARLY_OUT_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [CW-1:0]      fix_shift;
`endif

    md_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i(is_div_q),
        .acc_i   (acc_q),
        .low_i   (low_q),
        .opnd_i  (opnd_q),
        .acc_o   (step_acc),
        .low_o   (step_low)
    );

    // Operand magnitudes and signs at issue time (unsigned ops never negate).
    always_comb begin
        a_neg = is_signed_funct(funct) & rs_val[WIDTH-1];
        b_neg = is_signed_funct(funct) & rt_val[WIDTH-1];
        abs_a = a_neg ? (~rs_val + 1'b1) : rs_val;
        abs_b = b_neg ? (~rt_val + 1'b1) : rt_val;
    end

    // Early multiply exit test and the sign-corrected results seen in FIX.
    always_comb begin
        early_exit = 1'b0;
        prod       = {acc_q[WIDTH-1:0], low_q};
`ifdef MD_EARLY_OUT_EN
        // After the step at count cnt_q, the untouched multiplier bits are
        // the low WIDTH-1-cnt_q bits of step_low.
        rem_mask   = {WIDTH{1'b1}} >> (32'(cnt_q) + 32'd1);
        early_exit = !is_div_q && ((step_low & rem_mask) == '0);
        // Skipped iterations would only have shifted; do it in one go.
        fix_shift  = CW'(WIDTH - 1) - cnt_q;
        if (!is_div_q) begin
            prod = prod >> fix_shift;
        end
`endif
        prod_fx = neg_q     ? (~prod + 1'b1)              : prod;
        quo_fx  = neg_q     ? (~low_q + 1'b1)             : low_q;
        rem_fx  = rem_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1)  : acc_q[WIDTH-1:0];
    end

    // Next-state, datapath load/step and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // MTHI/MTLO land now even if an operation issues this cycle;
                // its result overwrites them later.
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush && is_md_funct(funct)) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    acc_d     = '0;
                    is_div_d  = is_div_funct(funct);
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = is_div_funct(funct) & a_neg;
                    if (is_div_funct(funct)) begin
                        low_d  = abs_a;
                        opnd_d = abs_b;
                    end else begin
                        low_d  = abs_b;
                        opnd_d = abs_a;
                    end
                end
            end
            RUN: begin
                acc_d = step_acc;
                low_d = step_low;
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(WIDTH - 1) || early_exit) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fx;
                        lo_d = quo_fx;
                    end else begin
                        hi_d = prod_fx[2*WIDTH-1:WIDTH];
                        lo_d = prod_fx[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed corner cases from the
// multiply/divide rules plus randomized operations against a plain
// arithmetic reference model (64-bit products, native division).
`timescale 1ns/1ps
module tb_md_sequencer;

    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    md_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_md(input logic [5:0] fn, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        h  = '0;
        l  = '0;
        case (fn)
            F_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            F_MULT: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            F_DIVU: begin
                if (b == 0) begin
                    h = a;
                    l = '1;
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
            default: begin
                if (b == 0) begin
                    // all-ones magnitude quotient, negated when the dividend is negative
                    h = a;
                    l = a[W-1] ? 32'd1 : '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = '0;
                    l = 32'h8000_0000;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
        endcase
    endfunction

    // Number of RUN cycles: W, or for early-exit multiplies the position of
    // the highest set multiplier magnitude bit plus one (at least one).
    function automatic int ref_run_cycles(input logic [5:0] fn, input logic [W-1:0] b);
        logic [W-1:0] m;
        int           msb_run;
        m       = (fn == F_MULT && b[W-1]) ? (32'd0 - b) : b;
        msb_run = 1;
        for (int i = 0; i < W; i++) begin
            if (m[i]) msb_run = i + 1;
        end
        return (EARLY && (fn == F_MULT || fn == F_MULTU)) ? msb_run : W;
    endfunction

    // ---------------- driver tasks ----------------
    // Issue one operation and follow it to completion. with_mthi drives an
    // MTHI in the issue cycle; poke_busy tries a start/MTHI/MTLO mid-operation.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit with_mthi, input bit poke_busy);
        logic [W-1:0] eh, el, gh, gl;
        int           runs, j, busy_cnt;
        ref_md(fn, a, b, eh, el);
        runs = ref_run_cycles(fn, b);
        exp_q.push_back(eh);
        exp_q.push_back(el);
        @(negedge clk);
        start  = 1'b1;
        funct  = fn;
        rs_val = a;
        rt_val = b;
        hi_we  = with_mthi;
        wdata  = 32'h5A5A_0F0F;
        @(negedge clk);
        start  = 1'b0;
        hi_we  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        if (with_mthi) check($sformatf("%s.mthi_at_issue", tag), hi, 32'h5A5A_0F0F);
        j        = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && j < 200) begin
            if (busy === 1'b1) busy_cnt++;
            if (poke_busy && j == 1) begin
                start = 1'b1;
                funct = F_MULTU;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        // edges counted including the start-sampling edge
        check($sformatf("%s.latency", tag), j + 1, runs + 2);
        check($sformatf("%s.busy_cycles", tag), busy_cnt, runs + 1);
        check($sformatf("%s.busy_at_done", tag), busy, 1'b0);
        gh = exp_q.pop_front();
        gl = exp_q.pop_front();
        check($sformatf("%s.hi", tag), hi, gh);
        check($sformatf("%s.lo", tag), lo, gl);
        model_hi = gh;
        model_lo = gl;
        @(negedge clk);
        check($sformatf("%s.done_pulse", tag), done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]   fn;
        logic [W-1:0] a, b;
        int           done_seen;
        rst    = 1'b1;
        start  = 1'b0;
        funct  = '0;
        rs_val = '0;
        rt_val = '0;
        flush  = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        model_hi = '0;
        model_lo = '0;
        repeat (3) @(negedge clk);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        rst = 1'b0;

        // directed corner cases
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mult_neg7x3", F_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
        run_op("div_neg7by2", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu_by0", F_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op("div_by0_neg", F_DIV, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b0);
        run_op("div_min_by_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mult_by0", F_MULT, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op("mthi_with_start", F_MULTU, 32'd7, 32'd9, 1'b1, 1'b0);
        run_op("busy_poke", F_DIVU, 32'd1000, 32'd7, 1'b0, 1'b1);

        // flush mid-DIVU: HI/LO keep the previous result, no done pulse
        @(negedge clk);
        start  = 1'b1;
        funct  = F_DIVU;
        rs_val = 32'd10;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        funct = F_MULT;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", busy, 1'b0);
        check("flush.hi", hi, model_hi);
        check("flush.lo", lo, model_lo);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("flush.quiet_after", done_seen, 0);

        // MTLO / MTHI in IDLE
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo.lo", lo, 32'h0000_1234);
        check("mtlo.hi", hi, model_hi);
        hi_we = 1'b1;
        wdata = 32'h0000_ABCD;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi.hi", hi, 32'h0000_ABCD);
        model_hi = 32'h0000_ABCD;
        model_lo = 32'h0000_1234;

        // flush together with start, and an illegal funct: nothing issues
        start  = 1'b1;
        flush  = 1'b1;
        funct  = F_MULTU;
        rs_val = 32'd3;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start.busy", busy, 1'b0);
        start = 1'b1;
        funct = 6'b100000;
        @(negedge clk);
        start = 1'b0;
        check("bad_funct.busy", busy, 1'b0);
        check("bad_funct.lo", lo, model_lo);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start  = 1'b1;
        funct  = F_MULTU;
        rs_val = 32'hFFFF_0000;
        rt_val = 32'hFFFF_0001;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.hi", hi, 32'd0);
        check("midrst.lo", lo, 32'd0);
        check("midrst.busy", busy, 1'b0);
        check("midrst.done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst_5x3", F_MULTU, 32'd5, 32'd3, 1'b0, 1'b0);

        // randomized operations
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       fn = F_MULT;
                1:       fn = F_MULTU;
                2:       fn = F_DIV;
                default: fn = F_DIVU;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), fn, a, b, ($urandom_range(0, 3) == 0),
                   ((i % 4) == 3));
        end

        check("scoreboard.drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
